// File: rtl/ad_acq_scheduler.sv
// ---------------------------------------------------------------------------
// ad_acq_scheduler
//
// Sequences AD acquisitions for the thickness channel. For every frame the
// block latches the rate configuration, holds the sampler in soft reset
// while its clock mux settles, then fires cfg_avg_num bursts spaced at
// least cfg_prf_div clk_100 cycles apart. Each burst is a burst_syn request
// that is closed by AD_data_valid rising and then falling. Frame completion,
// abort and watchdog errors are reported to the host register block.
//
// Handshake: burst_syn is raised on FIRE entry and held through CAPTURE.
// The sampler answers by raising AD_data_valid for the length of the
// capture; the shot is complete once the synchronised valid falls. After
// the shot burst_syn stays low for at least GUARD cycles and until the
// synchronised valid reads low before the next shot may start.
//
// Ports
//   clk_100        in   1   system clock, 100 MHz
//   RESET_N        in   1   asynchronous, active-low reset
//   cfg_start      in   1   1-cycle pulse, begin frame (IDLE only)
//   cfg_stop       in   1   1-cycle pulse, abort after the current shot
//   cfg_rate       in   2   0=25 MHz, 1=50 MHz, 2=100 MHz, 3 treated as 0
//   cfg_avg_num    in   8   shots per frame, 0 treated as 1
//   cfg_prf_div    in   24  minimum shot-to-shot period in clk_100 cycles
//   AD_data_valid  in   1   sampler valid (clk_sample domain)
//   burst_syn      out  1   burst/fire request to sampler
//   AD_sample_flag out  2   latched rate select to sampler
//   reset_n        out  1   sampler soft reset, active-low
//   busy           out  1   high in every state except IDLE
//   shot_idx       out  8   0-based index of the current shot
//   frame_done     out  1   1-cycle pulse at end of frame
//   frame_abort    out  1   frame ended by cfg_stop (qualifies frame_done)
//   wdog_err       out  1   sticky watchdog flag, cleared by next start
//   dbg_state      out  3   current FSM state encoding
// ---------------------------------------------------------------------------
module ad_acq_scheduler #(
   parameter int unsigned ARM_CYCLES  = 8,
   parameter int unsigned WDOG_CYCLES = 40000,
   parameter int unsigned GUARD       = 4
) (
   input  logic        clk_100,
   input  logic        RESET_N,
   input  logic        cfg_start,
   input  logic        cfg_stop,
   input  logic [1:0]  cfg_rate,
   input  logic [7:0]  cfg_avg_num,
   input  logic [23:0] cfg_prf_div,
   input  logic        AD_data_valid,
   output logic        burst_syn,
   output logic [1:0]  AD_sample_flag,
   output logic        reset_n,
   output logic        busy,
   output logic [7:0]  shot_idx,
   output logic        frame_done,
   output logic        frame_abort,
   output logic        wdog_err,
   output logic [2:0]  dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_ARM      = 3'd1,
      S_FIRE     = 3'd2,
      S_CAPTURE  = 3'd3,
      S_RELEASE  = 3'd4,
      S_WAIT_PRF = 3'd5,
      S_ERR      = 3'd6,
      S_DONE     = 3'd7
   } state_t;

   localparam logic [3:0]  ARM_LAST   = 4'(ARM_CYCLES - 1);
   localparam logic [3:0]  GUARD_LAST = 4'(GUARD - 1);
   localparam logic [15:0] WD_LAST    = 16'(WDOG_CYCLES - 1);

   state_t      state;
   state_t      state_nxt;

   // synchroniser: sync1 -> vs (usable) -> sync3 (edge reference)
   logic        sync1;
   logic        vs;
   logic        sync3;
   logic        vs_rise;
   logic        vs_fall;

   logic [23:0] prf_cnt;
   logic [15:0] wd_cnt;
   logic [3:0]  gcnt;
   logic [7:0]  avg_lat;
   logic        stop_pend;

   logic        start_acc;
   logic        abort_set;
   logic        shot_inc;
   logic        state_chg;
   logic        prf_elapsed;
   logic        last_shot;
   logic        stop_now;

   assign vs_rise   = vs & ~sync3;
   assign vs_fall   = ~vs & sync3;
   assign state_chg = (state_nxt != state);
   assign start_acc = (state == S_IDLE) && cfg_start;
   assign stop_now  = stop_pend | cfg_stop;

   // 25-bit compare so that cfg_prf_div==0 behaves as "already elapsed"
   // instead of wrapping to a huge period.
   assign prf_elapsed = ({1'b0, prf_cnt} + 25'd1) >= {1'b0, cfg_prf_div};
   assign last_shot   = ({1'b0, shot_idx} + 9'd1) == {1'b0, avg_lat};

   assign dbg_state = state;

   // ------------------------------------------------------------------
   // Synchroniser
   // ------------------------------------------------------------------
   always_ff @(posedge clk_100 or negedge RESET_N) begin
      if (!RESET_N) begin
         sync1 <= 1'b0;
         vs    <= 1'b0;
         sync3 <= 1'b0;
      end else begin
         sync1 <= AD_data_valid;
         vs    <= sync1;
         sync3 <= vs;
      end
   end

   // ------------------------------------------------------------------
   // FSM state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk_100 or negedge RESET_N) begin
      if (!RESET_N) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ------------------------------------------------------------------
   // FSM next state and state-decoded outputs
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt  = state;
      abort_set  = 1'b0;
      shot_inc   = 1'b0;
      burst_syn  = 1'b0;
      reset_n    = 1'b0;
      busy       = 1'b1;
      frame_done = 1'b0;
      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (cfg_start) begin
               state_nxt = S_ARM;
            end
         end
         S_ARM: begin
            // A stop seen during ARM ends the frame without firing.
            if (gcnt == ARM_LAST) begin
               if (stop_now) begin
                  state_nxt = S_DONE;
                  abort_set = 1'b1;
               end else begin
                  state_nxt = S_FIRE;
               end
            end
         end
         S_FIRE: begin
            burst_syn = 1'b1;
            reset_n   = 1'b1;
            if (vs_rise) begin
               state_nxt = S_CAPTURE;
            end else if (wd_cnt == WD_LAST) begin
               state_nxt = S_ERR;
            end
         end
         S_CAPTURE: begin
            burst_syn = 1'b1;
            reset_n   = 1'b1;
            if (vs_fall) begin
               state_nxt = S_RELEASE;
            end else if (wd_cnt == WD_LAST) begin
               state_nxt = S_ERR;
            end
         end
         S_RELEASE: begin
            reset_n = 1'b1;
            if ((gcnt >= GUARD_LAST) && !vs) begin
               if (stop_now) begin
                  state_nxt = S_DONE;
                  abort_set = 1'b1;
               end else if (last_shot) begin
                  state_nxt = S_DONE;
               end else begin
                  state_nxt = S_WAIT_PRF;
               end
            end
         end
         S_WAIT_PRF: begin
            reset_n = 1'b1;
            if (cfg_stop) begin
               state_nxt = S_DONE;
               abort_set = 1'b1;
            end else if (prf_elapsed) begin
               state_nxt = S_FIRE;
               shot_inc  = 1'b1;
            end
         end
         S_ERR: begin
            state_nxt = S_DONE;
         end
         S_DONE: begin
            frame_done = 1'b1;
            state_nxt  = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Counters
   // ------------------------------------------------------------------
   always_ff @(posedge clk_100 or negedge RESET_N) begin
      if (!RESET_N) begin
         prf_cnt <= '0;
         wd_cnt  <= '0;
         gcnt    <= '0;
      end else begin
         // prf_cnt measures the period from one FIRE entry to the next.
         if ((state_nxt == S_FIRE) && (state != S_FIRE)) begin
            prf_cnt <= '0;
         end else if (prf_cnt != 24'hFF_FFFF) begin
            prf_cnt <= prf_cnt + 24'd1;
         end

         if (state_chg) begin
            wd_cnt <= '0;
         end else if (wd_cnt != 16'hFFFF) begin
            wd_cnt <= wd_cnt + 16'd1;
         end

         if (state_chg) begin
            gcnt <= '0;
         end else if (gcnt != 4'hF) begin
            gcnt <= gcnt + 4'd1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Frame registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk_100 or negedge RESET_N) begin
      if (!RESET_N) begin
         AD_sample_flag <= 2'd0;
         avg_lat        <= 8'd1;
         shot_idx       <= 8'd0;
         frame_abort    <= 1'b0;
         wdog_err       <= 1'b0;
         stop_pend      <= 1'b0;
      end else begin
         if (start_acc) begin
            // Rate changes only here, while reset_n holds the sampler low,
            // so the sampler clock mux never switches under a live sampler.
            AD_sample_flag <= (cfg_rate == 2'd3) ? 2'd0 : cfg_rate;
            avg_lat        <= (cfg_avg_num == 8'd0) ? 8'd1 : cfg_avg_num;
            shot_idx       <= 8'd0;
            frame_abort    <= 1'b0;
            wdog_err       <= 1'b0;
         end else begin
            if (shot_inc) begin
               shot_idx <= shot_idx + 8'd1;
            end
            if (abort_set) begin
               frame_abort <= 1'b1;
            end
            if ((state_nxt == S_ERR) && (state != S_ERR)) begin
               wdog_err <= 1'b1;
            end
         end

         if ((state_nxt == S_IDLE) && (state != S_IDLE)) begin
            stop_pend <= 1'b0;
         end else if (cfg_stop && ((state == S_ARM) || (state == S_FIRE) ||
                                   (state == S_CAPTURE) || (state == S_RELEASE))) begin
            stop_pend <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ad_acq_scheduler.sv
// ---------------------------------------------------------------------------
// tb_ad_acq_scheduler
//
// Bench for ad_acq_scheduler. A behavioural sampler answers each burst_syn
// rise with a valid pulse of programmable latency and length. Expected shot
// times are computed from the timing rules: first FIRE ARM_CYCLES+1 cycles
// after the start pulse, shot period max(prf, lat+hold+GUARD+4), frame end
// lat+hold+3+GUARD cycles after the last FIRE.
// ---------------------------------------------------------------------------
module tb_ad_acq_scheduler;

   localparam int ARM  = 8;
   localparam int GRD  = 4;
   localparam int WDOG = 600;

   logic        clk_100 = 1'b0;
   logic        RESET_N = 1'b1;
   logic        cfg_start = 1'b0;
   logic        cfg_stop = 1'b0;
   logic [1:0]  cfg_rate = 2'd0;
   logic [7:0]  cfg_avg_num = 8'd0;
   logic [23:0] cfg_prf_div = 24'd0;
   logic        AD_data_valid = 1'b0;
   logic        burst_syn;
   logic [1:0]  AD_sample_flag;
   logic        reset_n;
   logic        busy;
   logic [7:0]  shot_idx;
   logic        frame_done;
   logic        frame_abort;
   logic        wdog_err;
   logic [2:0]  dbg_state;

   int checks = 0;
   int errors = 0;

   ad_acq_scheduler #(
      .ARM_CYCLES  (ARM),
      .WDOG_CYCLES (WDOG),
      .GUARD       (GRD)
   ) dut (
      .clk_100        (clk_100),
      .RESET_N        (RESET_N),
      .cfg_start      (cfg_start),
      .cfg_stop       (cfg_stop),
      .cfg_rate       (cfg_rate),
      .cfg_avg_num    (cfg_avg_num),
      .cfg_prf_div    (cfg_prf_div),
      .AD_data_valid  (AD_data_valid),
      .burst_syn      (burst_syn),
      .AD_sample_flag (AD_sample_flag),
      .reset_n        (reset_n),
      .busy           (busy),
      .shot_idx       (shot_idx),
      .frame_done     (frame_done),
      .frame_abort    (frame_abort),
      .wdog_err       (wdog_err),
      .dbg_state      (dbg_state)
   );

   // ------------------------------------------------------------------
   // Clock and cycle counter
   // ------------------------------------------------------------------
   always #5 clk_100 = ~clk_100;

   int cyc = 0;
   always @(posedge clk_100) cyc <= cyc + 1;

   // ------------------------------------------------------------------
   // Sampler model
   // ------------------------------------------------------------------
   bit   samp_en = 1'b0;
   int   s_lat = 0;
   int   s_hold = 2;
   int   samp_cnt = 0;
   bit   samp_act = 1'b0;
   logic samp_prev = 1'b0;

   always @(negedge clk_100) begin
      if (!samp_en) begin
         AD_data_valid = 1'b0;
         samp_act = 1'b0;
      end else begin
         if (burst_syn && !samp_prev) begin
            samp_act = 1'b1;
            samp_cnt = 0;
         end
         if (samp_act) begin
            if (samp_cnt == s_lat) AD_data_valid = 1'b1;
            if (samp_cnt == s_lat + s_hold) begin
               AD_data_valid = 1'b0;
               samp_act = 1'b0;
            end
            samp_cnt++;
         end
      end
      samp_prev = burst_syn;
   end

   // ------------------------------------------------------------------
   // Monitor
   // ------------------------------------------------------------------
   int   fire_cyc_q[$];
   int   fire_idx_q[$];
   int   fire_flag_q[$];
   int   fire_rstn_q[$];
   int   done_cnt = 0;
   int   done_cyc = 0;
   logic done_abort = 1'b0;
   logic done_wdog = 1'b0;
   logic done_rstn = 1'b0;
   logic mon_prev = 1'b0;

   always @(negedge clk_100) begin
      if (burst_syn && !mon_prev) begin
         fire_cyc_q.push_back(cyc);
         fire_idx_q.push_back(int'(shot_idx));
         fire_flag_q.push_back(int'(AD_sample_flag));
         fire_rstn_q.push_back(int'(reset_n));
      end
      if (frame_done) begin
         done_cnt++;
         done_cyc = cyc;
         done_abort = frame_abort;
         done_wdog = wdog_err;
         done_rstn = reset_n;
      end
      mon_prev = burst_syn;
   end

   // ------------------------------------------------------------------
   // Scoreboard helpers
   // ------------------------------------------------------------------
   logic [31:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic clear_mon();
      fire_cyc_q.delete();
      fire_idx_q.delete();
      fire_flag_q.delete();
      fire_rstn_q.delete();
      exp_q.delete();
      done_cnt = 0;
   endtask

   // stop_mode: 0 none, 1 stop in CAPTURE of shot stop_shot,
   //            2 stop during ARM, 3 stop in WAIT_PRF after shot stop_shot
   task automatic run_frame(input int rate, input int avg, input int prf,
                            input int lat, input int hold, input int stop_mode,
                            input int stop_shot, input bit start_busy,
                            input bit start_with_stop);
      int n;
      int n_exp;
      int per;
      int c0;
      int fire0;
      int stop_cyc;
      int done_exp;
      int abort_exp;
      int flag_exp;
      int budget;
      int wait_entry;
      clear_mon();
      s_lat = lat;
      s_hold = hold;
      samp_en = 1'b1;
      n = (avg == 0) ? 1 : avg;
      per = (prf > lat + hold + GRD + 4) ? prf : lat + hold + GRD + 4;
      flag_exp = (rate == 3) ? 0 : rate;

      cfg_rate = 2'(rate);
      cfg_avg_num = 8'(avg);
      cfg_prf_div = 24'(prf);
      cfg_start = 1'b1;
      cfg_stop = start_with_stop;
      c0 = cyc;
      @(negedge clk_100);
      cfg_start = 1'b0;
      cfg_stop = 1'b0;

      fire0 = c0 + 1 + ARM;
      stop_cyc = -1;
      abort_exp = 0;
      n_exp = n;
      if (stop_mode == 2) begin
         n_exp = 0;
         stop_cyc = c0 + 3;
         done_exp = c0 + 1 + ARM;
         abort_exp = 1;
      end else if (stop_mode == 3) begin
         n_exp = stop_shot + 1;
         wait_entry = fire0 + stop_shot * per + lat + hold + 3 + GRD;
         stop_cyc = wait_entry + 1;
         done_exp = stop_cyc + 1;
         abort_exp = 1;
      end else begin
         if (stop_mode == 1) begin
            n_exp = stop_shot + 1;
            stop_cyc = fire0 + stop_shot * per + lat + 4;
            abort_exp = 1;
         end
         done_exp = fire0 + (n_exp - 1) * per + lat + hold + 3 + GRD;
      end
      for (int i = 0; i < n_exp; i++) exp_q.push_back(32'(fire0 + i * per));

      check("arm_reset_n", {31'd0, reset_n}, 32'd0);
      check("arm_busy", {31'd0, busy}, 32'd1);
      check("arm_flag", {30'd0, AD_sample_flag}, 32'(flag_exp));
      check("arm_wdog_clr", {31'd0, wdog_err}, 32'd0);

      budget = n * (per + 10) + ARM + 200;
      for (int k = 0; k < budget && done_cnt == 0; k++) begin
         cfg_stop = (cyc == stop_cyc);
         cfg_start = start_busy && (cyc == fire0 + 2);
         @(negedge clk_100);
      end
      cfg_stop = 1'b0;
      cfg_start = 1'b0;
      repeat (3) @(negedge clk_100);

      check("done_cnt", 32'(done_cnt), 32'd1);
      check("done_cyc", 32'(done_cyc), 32'(done_exp));
      check("done_abort", {31'd0, done_abort}, 32'(abort_exp));
      check("done_wdog", {31'd0, done_wdog}, 32'd0);
      check("done_reset_n", {31'd0, done_rstn}, 32'd0);
      check("n_fires", 32'(fire_cyc_q.size()), 32'(n_exp));
      for (int i = 0; i < fire_cyc_q.size() && i < exp_q.size(); i++) begin
         check($sformatf("fire_cyc[%0d]", i), 32'(fire_cyc_q[i]), exp_q[i]);
         check($sformatf("shot_idx[%0d]", i), 32'(fire_idx_q[i]), 32'(i));
         check($sformatf("fire_flag[%0d]", i), 32'(fire_flag_q[i]), 32'(flag_exp));
         check($sformatf("fire_rstn[%0d]", i), 32'(fire_rstn_q[i]), 32'd1);
      end
      check("idle_busy", {31'd0, busy}, 32'd0);
      check("idle_reset_n", {31'd0, reset_n}, 32'd0);
      check("idle_burst", {31'd0, burst_syn}, 32'd0);
   endtask

   // ------------------------------------------------------------------
   // Directed and randomised sequence
   // ------------------------------------------------------------------
   initial begin : main
      int c0;
      int fire0;
      int budget;

      // reset
      #2 RESET_N = 1'b0;
      repeat (3) @(negedge clk_100);
      check("rst_burst", {31'd0, burst_syn}, 32'd0);
      check("rst_flag", {30'd0, AD_sample_flag}, 32'd0);
      check("rst_reset_n", {31'd0, reset_n}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_shot_idx", {24'd0, shot_idx}, 32'd0);
      check("rst_done", {31'd0, frame_done}, 32'd0);
      check("rst_abort", {31'd0, frame_abort}, 32'd0);
      check("rst_wdog", {31'd0, wdog_err}, 32'd0);
      RESET_N = 1'b1;
      repeat (2) @(negedge clk_100);

      // stop in IDLE is ignored
      cfg_stop = 1'b1;
      @(negedge clk_100);
      cfg_stop = 1'b0;
      @(negedge clk_100);
      check("idle_stop_busy", {31'd0, busy}, 32'd0);

      // single long capture at 100 MHz
      run_frame(2, 1, 1000, 0, 300, 0, 0, 1'b0, 1'b0);
      // period-limited shots, exact spacing
      run_frame(0, 4, 500, 2, 20, 0, 0, 1'b0, 1'b0);
      // prf below capture time: back-to-back shots
      run_frame(1, 3, 10, 1, 30, 0, 0, 1'b0, 1'b0);
      // rate 3 maps to 0, avg 0 maps to 1
      run_frame(3, 0, 0, 3, 5, 0, 0, 1'b0, 1'b0);
      // stop during shot 2 capture
      run_frame(1, 8, 100, 2, 20, 1, 2, 1'b0, 1'b0);
      // stop during ARM: no shot
      run_frame(2, 5, 100, 2, 10, 2, 0, 1'b0, 1'b0);
      // stop in WAIT_PRF after shot 1
      run_frame(0, 5, 500, 3, 20, 3, 1, 1'b0, 1'b0);
      // start while busy ignored; start+stop in IDLE accepted as start
      run_frame(1, 2, 80, 1, 15, 0, 0, 1'b1, 1'b1);

      // watchdog: sampler never answers
      clear_mon();
      samp_en = 1'b0;
      cfg_rate = 2'd1;
      cfg_avg_num = 8'd3;
      cfg_prf_div = 24'd100;
      cfg_start = 1'b1;
      c0 = cyc;
      @(negedge clk_100);
      cfg_start = 1'b0;
      fire0 = c0 + 1 + ARM;
      budget = WDOG + ARM + 100;
      for (int k = 0; k < budget && done_cnt == 0; k++) @(negedge clk_100);
      repeat (2) @(negedge clk_100);
      check("wd_done_cnt", 32'(done_cnt), 32'd1);
      check("wd_done_cyc", 32'(done_cyc), 32'(fire0 + WDOG + 1));
      check("wd_err_at_done", {31'd0, done_wdog}, 32'd1);
      check("wd_abort", {31'd0, done_abort}, 32'd0);
      check("wd_reset_n", {31'd0, done_rstn}, 32'd0);
      check("wd_fires", 32'(fire_cyc_q.size()), 32'd1);
      check("wd_sticky", {31'd0, wdog_err}, 32'd1);
      // next frame must clear it (checked in ARM by run_frame)
      run_frame(0, 2, 60, 1, 10, 0, 0, 1'b0, 1'b0);

      // asynchronous reset in the middle of CAPTURE
      clear_mon();
      s_lat = 2;
      s_hold = 60;
      samp_en = 1'b1;
      cfg_rate = 2'd2;
      cfg_avg_num = 8'd2;
      cfg_prf_div = 24'd100;
      cfg_start = 1'b1;
      c0 = cyc;
      @(negedge clk_100);
      cfg_start = 1'b0;
      fire0 = c0 + 1 + ARM;
      for (int k = 0; k < 200 && cyc < fire0 + 2 + 3 + 10; k++) @(negedge clk_100);
      check("pre_rst_burst", {31'd0, burst_syn}, 32'd1);
      RESET_N = 1'b0;
      #1;
      check("mid_rst_burst", {31'd0, burst_syn}, 32'd0);
      check("mid_rst_reset_n", {31'd0, reset_n}, 32'd0);
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      check("mid_rst_flag", {30'd0, AD_sample_flag}, 32'd0);
      samp_en = 1'b0;
      repeat (3) @(negedge clk_100);
      RESET_N = 1'b1;
      repeat (3) @(negedge clk_100);
      check("mid_rst_no_done", 32'(done_cnt), 32'd0);
      run_frame(2, 0, 50, 1, 12, 0, 0, 1'b0, 1'b0);

      // randomised frames
      for (int r = 0; r < 6; r++) begin
         run_frame(int'($urandom_range(0, 3)), int'($urandom_range(0, 5)),
                   int'($urandom_range(0, 250)), int'($urandom_range(0, 6)),
                   int'($urandom_range(2, 60)), 0, 0, 1'b0, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
